// File: rtl/pattern_programmer.sv
`default_nettype none
// ============================================================================
// Module      : pattern_programmer
// Description : Per-drum pattern edit buffers driven from front-panel controls
//               through a step cursor. A commit transfers the selected drum's
//               buffer to that drum's controller over a valid/ack handshake.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   system clock, rising edge
//   rst            in   asynchronous active-high reset
//   en_i_n         in   active-low enable for user commands
//   drum_sel_i     in   [SEL_WIDTH]     selected drum index
//   cursor_inc_i   in   pulse: advance step cursor (wraps at PATTERN_WIDTH)
//   toggle_i       in   pulse: invert bit at cursor of selected drum
//   clear_i        in   pulse: zero selected drum's buffer (beats toggle)
//   commit_i       in   pulse: start load of selected drum's buffer
//   load_ack_i     in   acknowledge from target drum controller
//   load_valid_o   out  load request valid
//   load_sel_o     out  [DRUM_COUNT]    one-hot target, zero when idle
//   load_data_o    out  [PATTERN_WIDTH] pattern being loaded
//   edit_pattern_o out  [PATTERN_WIDTH] selected drum's buffer (display)
//   cursor_o       out  [COUNT_WIDTH]   current step cursor
//   busy_o         out  FSM not idle
//   done_o         out  one-cycle pulse on successful load
//   timeout_o      out  one-cycle pulse on aborted load
// Optional feature macro: PATTERN_LOAD_TIMEOUT_EN
//   When defined, a load with no ack for ACK_TIMEOUT cycles is aborted.
//   When undefined, a load waits indefinitely and timeout_o is tied 0.
// ============================================================================
module pattern_programmer #(
    parameter int PATTERN_WIDTH = 8,
    parameter int COUNT_WIDTH   = 4,
    parameter int DRUM_COUNT    = 5,
    parameter int SEL_WIDTH     = 3,
    parameter int ACK_TIMEOUT   = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en_i_n,
    input  logic [SEL_WIDTH-1:0]     drum_sel_i,
    input  logic                     cursor_inc_i,
    input  logic                     toggle_i,
    input  logic                     clear_i,
    input  logic                     commit_i,
    input  logic                     load_ack_i,
    output logic                     load_valid_o,
    output logic [DRUM_COUNT-1:0]    load_sel_o,
    output logic [PATTERN_WIDTH-1:0] load_data_o,
    output logic [PATTERN_WIDTH-1:0] edit_pattern_o,
    output logic [COUNT_WIDTH-1:0]   cursor_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     timeout_o
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] c_CURSOR_LAST = COUNT_WIDTH'(PATTERN_WIDTH - 1);

    state_t                   r_state;
    state_t                   w_next_state;
    logic [PATTERN_WIDTH-1:0] r_buf [DRUM_COUNT];
    logic [COUNT_WIDTH-1:0]   r_cursor;
    logic [DRUM_COUNT-1:0]    r_sel;
    logic [PATTERN_WIDTH-1:0] r_data;
    logic                     r_done;
    logic                     r_timeout;

    logic                     w_sel_valid;
    logic [DRUM_COUNT-1:0]    w_sel_onehot;
    logic [PATTERN_WIDTH-1:0] w_sel_pattern;
    logic [PATTERN_WIDTH-1:0] w_toggle_mask;
    logic                     w_edit_ok;
    logic                     w_start;
    logic                     w_ack_done;
    logic                     w_expire;

    // Decode the select once; out-of-range selects give an all-zero one-hot
    // which both blanks the display and disables edits/commit.
    always_comb begin
        w_sel_onehot  = '0;
        w_sel_pattern = '0;
        for (int i = 0; i < DRUM_COUNT; i++) begin
            if (drum_sel_i == SEL_WIDTH'(i)) begin
                w_sel_onehot[i] = 1'b1;
                w_sel_pattern   = r_buf[i];
            end
        end
    end

    assign w_sel_valid   = |w_sel_onehot;
    assign w_edit_ok     = ~en_i_n & w_sel_valid;
    assign w_toggle_mask = PATTERN_WIDTH'(1) << r_cursor;

    // Cursor acts even with an invalid select, but not when disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cursor <= '0;
        end else if (~en_i_n && cursor_inc_i) begin
            r_cursor <= (r_cursor == c_CURSOR_LAST) ? '0 : r_cursor + 1'b1;
        end
    end

    // Edit buffers. Toggle uses the pre-increment cursor since r_cursor is
    // only updated on this same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DRUM_COUNT; i++) begin
                r_buf[i] <= '0;
            end
        end else if (w_edit_ok) begin
            for (int i = 0; i < DRUM_COUNT; i++) begin
                if (w_sel_onehot[i]) begin
                    if (clear_i) begin
                        r_buf[i] <= '0;
                    end else if (toggle_i) begin
                        r_buf[i] <= r_buf[i] ^ w_toggle_mask;
                    end
                end
            end
        end
    end

`ifdef PATTERN_LOAD_TIMEOUT_EN
    localparam int c_TO_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(ACK_TIMEOUT - 1);
    logic [c_TO_W-1:0] r_to_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (w_start) begin
            r_to_cnt <= '0;
        end else if (r_state == LOAD) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Commit is only accepted in IDLE; commits during LOAD are dropped.
    // Ack wins over expiry when both land on the same edge.
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_ack_done   = 1'b0;
        w_expire     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_edit_ok && commit_i) begin
                    w_next_state = LOAD;
                    w_start      = 1'b1;
                end
            end
            LOAD: begin
                if (load_ack_i) begin
                    w_next_state = IDLE;
                    w_ack_done   = 1'b1;
                end
`ifdef PATTERN_LOAD_TIMEOUT_EN
                else if (r_to_cnt == c_TO_LAST) begin
                    w_next_state = IDLE;
                    w_expire     = 1'b1;
                end
`endif
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Load payload: snapshot is the pre-edit buffer value; data is held
    // after the transfer completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel     <= '0;
            r_data    <= '0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_done    <= w_ack_done;
            r_timeout <= w_expire;
            if (w_start) begin
                r_sel  <= w_sel_onehot;
                r_data <= w_sel_pattern;
            end else if (w_ack_done || w_expire) begin
                r_sel  <= '0;
            end
        end
    end

    assign load_valid_o   = (r_state == LOAD);
    assign busy_o         = (r_state != IDLE);
    assign load_sel_o     = r_sel;
    assign load_data_o    = r_data;
    assign edit_pattern_o = w_sel_pattern;
    assign cursor_o       = r_cursor;
    assign done_o         = r_done;
    assign timeout_o      = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_pattern_programmer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pattern_programmer
// Description : Directed self-checking bench for pattern_programmer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pattern_programmer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en_i_n = 1'b0;
    logic [2:0] drum_sel_i = '0;
    logic       cursor_inc_i = 1'b0;
    logic       toggle_i = 1'b0;
    logic       clear_i = 1'b0;
    logic       commit_i = 1'b0;
    logic       load_ack_i = 1'b0;
    logic       load_valid_o;
    logic [4:0] load_sel_o;
    logic [7:0] load_data_o;
    logic [7:0] edit_pattern_o;
    logic [3:0] cursor_o;
    logic       busy_o;
    logic       done_o;
    logic       timeout_o;

    int n_cmp = 0;
    int n_bad = 0;

    pattern_programmer dut (
        .clk            (clk),
        .rst            (rst),
        .en_i_n         (en_i_n),
        .drum_sel_i     (drum_sel_i),
        .cursor_inc_i   (cursor_inc_i),
        .toggle_i       (toggle_i),
        .clear_i        (clear_i),
        .commit_i       (commit_i),
        .load_ack_i     (load_ack_i),
        .load_valid_o   (load_valid_o),
        .load_sel_o     (load_sel_o),
        .load_data_o    (load_data_o),
        .edit_pattern_o (edit_pattern_o),
        .cursor_o       (cursor_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .timeout_o      (timeout_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_inc(input int n);
        for (int k = 0; k < n; k++) begin
            cursor_inc_i = 1'b1;
            step();
            cursor_inc_i = 1'b0;
        end
    endtask

    task automatic pulse_toggle();
        toggle_i = 1'b1;
        step();
        toggle_i = 1'b0;
    endtask

    task automatic pulse_commit();
        commit_i = 1'b1;
        step();
        commit_i = 1'b0;
    endtask

    initial begin
        // ---------------- reset ----------------
        step();
        step();
        check("rst_valid", 32'(load_valid_o), 32'd0);
        check("rst_sel", 32'(load_sel_o), 32'd0);
        check("rst_data", 32'(load_data_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_timeout", 32'(timeout_o), 32'd0);
        check("rst_cursor", 32'(cursor_o), 32'd0);
        rst = 1'b0;
        step();

        // ---------------- editing via cursor ----------------
        drum_sel_i = 3'd2;
        pulse_toggle();        // bit 0
        pulse_inc(3);
        pulse_toggle();        // bit 3
        pulse_inc(4);
        pulse_toggle();        // bit 7
        check("edit_89", 32'(edit_pattern_o), 32'h89);
        check("cursor_7", 32'(cursor_o), 32'd7);
        pulse_inc(1);
        check("cursor_wrap", 32'(cursor_o), 32'd0);
        toggle_i = 1'b1;
        cursor_inc_i = 1'b1;
        step();
        toggle_i = 1'b0;
        cursor_inc_i = 1'b0;
        check("tog_inc_pat", 32'(edit_pattern_o), 32'h88);
        check("tog_inc_cur", 32'(cursor_o), 32'd1);
        pulse_inc(7);          // 1 -> 0
        pulse_toggle();
        check("restore_89", 32'(edit_pattern_o), 32'h89);

        // ---------------- commit / handshake ----------------
        pulse_commit();
        check("ld_valid", 32'(load_valid_o), 32'd1);
        check("ld_sel", 32'(load_sel_o), 32'b00100);
        check("ld_data", 32'(load_data_o), 32'h89);
        check("ld_busy", 32'(busy_o), 32'd1);
        pulse_toggle();        // cursor 0 -> buffer 0x88
        check("ld_edit_buf", 32'(edit_pattern_o), 32'h88);
        check("ld_data_hold", 32'(load_data_o), 32'h89);
        drum_sel_i = 3'd1;
        pulse_commit();        // dropped
        check("ld_second_sel", 32'(load_sel_o), 32'b00100);
        check("ld_second_data", 32'(load_data_o), 32'h89);
        step();
        check("ld_wait_done", 32'(done_o), 32'd0);
        load_ack_i = 1'b1;
        step();
        load_ack_i = 1'b0;
        check("ack_valid", 32'(load_valid_o), 32'd0);
        check("ack_sel", 32'(load_sel_o), 32'd0);
        check("ack_done", 32'(done_o), 32'd1);
        check("ack_busy", 32'(busy_o), 32'd0);
        check("ack_data_kept", 32'(load_data_o), 32'h89);
        step();
        check("done_pulse_end", 32'(done_o), 32'd0);
        check("no_queued_commit", 32'(load_valid_o), 32'd0);
        load_ack_i = 1'b1;
        step();
        load_ack_i = 1'b0;
        check("idle_ack_done", 32'(done_o), 32'd0);

        // ---------------- disabled controls ----------------
        drum_sel_i = 3'd2;
        en_i_n = 1'b1;
        toggle_i = 1'b1;
        commit_i = 1'b1;
        cursor_inc_i = 1'b1;
        step();
        toggle_i = 1'b0;
        commit_i = 1'b0;
        cursor_inc_i = 1'b0;
        en_i_n = 1'b0;
        check("dis_pat", 32'(edit_pattern_o), 32'h88);
        check("dis_busy", 32'(busy_o), 32'd0);
        check("dis_cursor", 32'(cursor_o), 32'd0);

        // ---------------- invalid select ----------------
        drum_sel_i = 3'd6;
        #1;
        check("bad_sel_pat", 32'(edit_pattern_o), 32'd0);
        pulse_commit();
        check("bad_sel_busy", 32'(busy_o), 32'd0);
        pulse_toggle();
        pulse_inc(1);
        check("bad_sel_cursor", 32'(cursor_o), 32'd1);
        drum_sel_i = 3'd2;
        #1;
        check("bad_sel_no_edit", 32'(edit_pattern_o), 32'h88);

        // ---------------- clear priority ----------------
        drum_sel_i = 3'd0;
        for (int k = 0; k < 8; k++) begin
            toggle_i = 1'b1;
            cursor_inc_i = 1'b1;
            step();
        end
        toggle_i = 1'b0;
        cursor_inc_i = 1'b0;
        check("fill_ff", 32'(edit_pattern_o), 32'hFF);
        clear_i = 1'b1;
        toggle_i = 1'b1;
        step();
        clear_i = 1'b0;
        toggle_i = 1'b0;
        check("clear_wins", 32'(edit_pattern_o), 32'h00);

        // ---------------- reset mid-LOAD ----------------
        pulse_toggle();        // cursor 1 -> 0x02
        pulse_commit();
        check("r_ld_sel", 32'(load_sel_o), 32'b00001);
        check("r_ld_data", 32'(load_data_o), 32'h02);
        #2;
        rst = 1'b1;
        #1;
        check("async_valid", 32'(load_valid_o), 32'd0);
        check("async_busy", 32'(busy_o), 32'd0);
        check("async_pat0", 32'(edit_pattern_o), 32'd0);
        step();
        rst = 1'b0;
        check("async_done", 32'(done_o), 32'd0);
        drum_sel_i = 3'd2;
        #1;
        check("async_pat2", 32'(edit_pattern_o), 32'd0);
        check("async_cursor", 32'(cursor_o), 32'd0);

        // ---------------- commit snapshot vs same-cycle edit ----------------
        pulse_toggle();        // 0x01
        commit_i = 1'b1;
        toggle_i = 1'b1;
        step();
        commit_i = 1'b0;
        toggle_i = 1'b0;
        check("snap_data", 32'(load_data_o), 32'h01);
        check("snap_buf", 32'(edit_pattern_o), 32'h00);
        en_i_n = 1'b1;         // must not stall the handshake
        load_ack_i = 1'b1;
        step();
        load_ack_i = 1'b0;
        en_i_n = 1'b0;
        check("snap_done", 32'(done_o), 32'd1);

`ifdef PATTERN_LOAD_TIMEOUT_EN
        // ---------------- timeout ----------------
        step();
        pulse_commit();
        for (int k = 0; k < 14; k++) step();
        check("to_still_busy", 32'(busy_o), 32'd1);
        check("to_not_yet", 32'(timeout_o), 32'd0);
        step();
        check("to_pulse", 32'(timeout_o), 32'd1);
        check("to_busy", 32'(busy_o), 32'd0);
        check("to_sel", 32'(load_sel_o), 32'd0);
        step();
        check("to_pulse_end", 32'(timeout_o), 32'd0);
        pulse_commit();
        for (int k = 0; k < 14; k++) step();
        load_ack_i = 1'b1;
        step();
        load_ack_i = 1'b0;
        check("to_race_done", 32'(done_o), 32'd1);
        check("to_race_to", 32'(timeout_o), 32'd0);
`else
        // ---------------- no timeout: load waits indefinitely ----------------
        step();
        pulse_commit();
        for (int k = 0; k < 20; k++) step();
        check("nto_busy", 32'(busy_o), 32'd1);
        check("nto_timeout", 32'(timeout_o), 32'd0);
        load_ack_i = 1'b1;
        step();
        load_ack_i = 1'b0;
        check("nto_done", 32'(done_o), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pattern_programmer.md
Name: pattern_programmer

Overview:
- Write-side counterpart of the drum pattern player. Holds one PATTERN_WIDTH-bit edit buffer per drum, edited from user controls through a step cursor.
- On commit, transfers the selected drum's buffer to that drum's controller over a valid/ack load handshake.
- Sits between the front-panel input logic and the bank of drum controllers.

Parameters:
- PATTERN_WIDTH, 8: steps per pattern (bits per edit buffer).
- COUNT_WIDTH, 4: cursor width; 2**COUNT_WIDTH >= PATTERN_WIDTH is required.
- DRUM_COUNT, 5: number of drums / edit buffers / load targets.
- SEL_WIDTH, 3: width of the drum select input; 2**SEL_WIDTH >= DRUM_COUNT is required.
- ACK_TIMEOUT, 15: cycles to wait for ack before abort (optional feature only).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- en_i_n  input  1  active-low enable; when high, all user commands are ignored; the handshake still completes.
- drum_sel_i  input  SEL_WIDTH  selected drum index.
- cursor_inc_i  input  1  single-cycle pulse: advance step cursor.
- toggle_i  input  1  single-cycle pulse: invert the edit bit at the cursor for the selected drum.
- clear_i  input  1  single-cycle pulse: zero the selected drum's edit buffer.
- commit_i  input  1  single-cycle pulse: start a load of the selected drum's buffer.
- load_ack_i  input  1  acknowledge from the target drum controller.
- load_valid_o  output  1  load request valid.
- load_sel_o  output  DRUM_COUNT  one-hot target drum; all zero when not valid.
- load_data_o  output  PATTERN_WIDTH  pattern being loaded.
- edit_pattern_o  output  PATTERN_WIDTH  edit buffer of the selected drum, for display (combinational from drum_sel_i).
- cursor_o  output  COUNT_WIDTH  current step cursor.
- busy_o  output  1  high while the FSM is not IDLE.
- done_o  output  1  one-cycle pulse on a successful load.
- timeout_o  output  1  one-cycle pulse on an aborted load; tied 0 without the optional feature.

Behaviour:
- Reset (asynchronous): all edit buffers 0, cursor 0, FSM IDLE. load_valid_o, load_sel_o, load_data_o, busy_o, done_o and timeout_o are all 0.
- Cursor:
  - cursor_inc_i increments the cursor on the clock edge.
  - The cursor wraps from PATTERN_WIDTH-1 to 0. It is never allowed to reach a value >= PATTERN_WIDTH.
- Edit commands take effect only when en_i_n = 0 and drum_sel_i < DRUM_COUNT.
- Invalid select (drum_sel_i >= DRUM_COUNT): edit_pattern_o = 0, and toggle/clear/commit are ignored. cursor_inc_i still acts.
- Same-cycle priority:
  - clear_i overrides toggle_i on the same drum.
  - toggle_i uses the cursor value before that cycle's increment.
- Commit snapshot: load_data_o captures the buffer value present before that cycle's edits.
- FSM:
  - IDLE: valid commit_i -> LOAD on the next edge. At that edge: load_valid_o = 1, load_sel_o = one-hot(drum_sel_i), load_data_o = snapshot. Latency commit -> valid is 1 cycle.
  - LOAD: load_valid_o, load_sel_o and load_data_o hold stable. load_ack_i = 1 sampled on an edge -> IDLE. At that edge valid and sel clear and done_o pulses for 1 cycle. load_data_o keeps its last value.
  - commit_i arriving while in LOAD is dropped, not queued. The earliest new commit is in the first IDLE cycle.
- Ack sampled while in IDLE is ignored.
- Edits during LOAD are allowed on any drum, including the target. They change the buffer only, never load_data_o.
- en_i_n going high during LOAD does not stall or cancel the handshake.
- Reset mid-LOAD: valid drops immediately (async), buffers are cleared, and no done_o pulse is produced.

Optional Feature:
- Macro: PATTERN_LOAD_TIMEOUT_EN.
- Defined:
  - A counter runs while in LOAD. If ACK_TIMEOUT cycles elapse with no ack, the FSM returns to IDLE, valid and sel clear, and timeout_o pulses for 1 cycle.
  - An ack arriving on the same edge as expiry counts as success: done_o pulses, timeout_o does not.
- Undefined: no counter; LOAD waits indefinitely; timeout_o = 0.

Test Plan:
- Reset, then drum_sel_i=2; set cursor to 0,3,7 (via pulses) with toggle_i at each -> edit_pattern_o = 8'b1000_1001, cursor_o = 7.
- cursor_o = 7, one cursor_inc_i -> cursor_o = 0. toggle_i and cursor_inc_i in the same cycle at cursor 0 -> bit 0 flips, cursor_o = 1.
- drum 2 buffer 8'h89, commit_i -> next cycle load_valid_o=1, load_sel_o=5'b00100, load_data_o=8'h89, busy_o=1. Ack after 4 cycles -> valid low and done_o=1 for 1 cycle. A toggle on drum 2 during LOAD leaves load_data_o = 8'h89.
- Second commit_i during LOAD -> ignored. en_i_n=1 with toggle_i/commit_i -> buffers and FSM unchanged. drum_sel_i=6 -> edit_pattern_o=0 and commit ignored.
- Same cycle clear_i and toggle_i on drum 0 holding 8'hFF -> buffer 8'h00. Assert rst mid-LOAD -> load_valid_o=0 immediately, all buffers 0.
- With PATTERN_LOAD_TIMEOUT_EN and no ack -> after 15 cycles in LOAD, timeout_o pulses and busy_o=0. Ack on the expiry edge -> done_o=1, timeout_o=0.
